// File: rtl/div_unit_if.sv
// div_unit_if: handshake and data bundle between the execute stage and the
// iterative divider.
//   a, b        : dividend / divisor after E-stage forwarding
//   signed_div  : 1 = DIV, 0 = DIVU
//   start       : divide instruction sits in E (held while it stays there)
//   annul       : exception flush of E, aborts the operation
//   result      : {remainder, quotient} for HI/LO
//   ready       : result valid this cycle
//   stall_div   : stall request to the hazard unit (stall_divE)
// master = pipeline side, slave = divider side.
interface div_unit_if;
    logic [31:0] a;
    logic [31:0] b;
    logic        signed_div;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    logic        stall_div;

    modport master (
        output a, b, signed_div, start, annul,
        input  result, ready, stall_div
    );

    modport slave (
        input  a, b, signed_div, start, annul,
        output result, ready, stall_div
    );
endinterface

// File: rtl/div_unit.sv
// div_unit: iterative 32-bit restoring divider for DIV/DIVU in the E stage.
// One quotient bit per cycle; 33 stall cycles per divide including the
// entry cycle, with the result presented for one cycle in DONE.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : div_unit_if.slave (operands, start/annul, result/ready/stall_div)
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iteration and
// returns {a, 32'hFFFFFFFF} after a single stall cycle.
//
// state | meaning
// IDLE  | waiting for a divide in E; loads operands on start
// BUSY  | one restoring step per cycle, 32 steps
// DONE  | result valid, ready high; always returns to IDLE
module div_unit (
    input  logic     clk,
    input  logic     rst,
    div_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} divState_t;

    divState_t   state;
    divState_t   nextState;

    // [64:32] partial remainder, [31:0] dividend shifting out / quotient in
    logic [64:0] remQuo;
    logic [31:0] divisor;
    logic [5:0]  stepCount;
    logic        quoNeg;
    logic        remNeg;
    logic [63:0] resultReg;

    logic [31:0] absA;
    logic [31:0] absB;
    logic [64:0] shifted;
    logic [33:0] trialDiff;
    logic [64:0] nextRemQuo;
    logic [31:0] fixedQuo;
    logic [31:0] fixedRem;
    logic        lastStep;
    logic        loadOp;
    logic        stallDiv;

    // Datapath for the current step; magnitudes wrap at 32 bits, which makes
    // 0x80000000 / -1 come out right without special casing.
    always_comb begin
        absA       = (bus.signed_div && bus.a[31]) ? (~bus.a + 32'd1) : bus.a;
        absB       = (bus.signed_div && bus.b[31]) ? (~bus.b + 32'd1) : bus.b;
        shifted    = remQuo << 1;
        trialDiff  = {1'b0, shifted[64:32]} - {2'b00, divisor};
        nextRemQuo = trialDiff[33] ? shifted
                                   : {trialDiff[32:0], shifted[31:1], 1'b1};
        fixedQuo   = quoNeg ? (~nextRemQuo[31:0] + 32'd1) : nextRemQuo[31:0];
        fixedRem   = remNeg ? (~nextRemQuo[63:32] + 32'd1) : nextRemQuo[63:32];
        lastStep   = (stepCount == 6'd31);
        loadOp     = (state == IDLE) && bus.start && !bus.annul;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        stallDiv  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    stallDiv = 1'b1;
`ifdef DIV_ZERO_FAST_EN
                    nextState = (bus.b == 32'd0) ? DONE : BUSY;
`else
                    nextState = BUSY;
`endif
                end
            end
            BUSY: begin
                stallDiv = 1'b1;
                if (lastStep) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
        if (bus.annul) begin
            nextState = IDLE;
            stallDiv  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remQuo    <= '0;
            divisor   <= '0;
            stepCount <= '0;
            quoNeg    <= 1'b0;
            remNeg    <= 1'b0;
            resultReg <= '0;
        end else if (loadOp) begin
            remQuo    <= {33'd0, absA};
            divisor   <= absB;
            stepCount <= '0;
            quoNeg    <= bus.signed_div & (bus.a[31] ^ bus.b[31]);
            remNeg    <= bus.signed_div & bus.a[31];
`ifdef DIV_ZERO_FAST_EN
            if (bus.b == 32'd0) begin
                resultReg <= {bus.a, 32'hFFFF_FFFF};
            end
`endif
        end else if ((state == BUSY) && !bus.annul) begin
            remQuo    <= nextRemQuo;
            stepCount <= stepCount + 6'd1;
            if (lastStep) begin
                resultReg <= {fixedRem, fixedQuo};
            end
        end
    end

    assign bus.result    = resultReg;
    assign bus.ready     = (state == DONE);
    assign bus.stall_div = stallDiv;
endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;
    logic clk;
    logic rst;
    int   testCount;
    int   failCount;

    div_unit_if bus ();

    div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge with the DUT in IDLE. Holds start until
    // ready is seen, counting stall cycles including the entry cycle.
    task automatic runDiv(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic sgn, input int expStall, input logic [63:0] expRes);
        int stalls;
        int cyc;
        bit gotReady;
        stalls   = 0;
        cyc      = 0;
        gotReady = 1'b0;
        bus.a          = av;
        bus.b          = bv;
        bus.signed_div = sgn;
        bus.start      = 1'b1;
        while (!gotReady && cyc < 100) begin
            @(negedge clk);
            if (bus.stall_div) stalls++;
            if (bus.ready) begin
                gotReady = 1'b1;
                checkEq({tag, " result"}, bus.result, expRes);
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.start = 1'b0;
        checkEq({tag, " ready"}, 64'(gotReady), 64'd1);
        checkEq({tag, " stalls"}, 64'(stalls), 64'(expStall));
    endtask

    initial begin
        int zeroStall;
        testCount      = 0;
        failCount      = 0;
        rst            = 1'b1;
        bus.a          = '0;
        bus.b          = '0;
        bus.signed_div = 1'b0;
        bus.start      = 1'b0;
        bus.annul      = 1'b0;
`ifdef DIV_ZERO_FAST_EN
        zeroStall = 1;
`else
        zeroStall = 33;
`endif

        repeat (2) @(posedge clk);
        #1;
        checkEq("reset result", bus.result, 64'd0);
        checkEq("reset ready", 64'(bus.ready), 64'd0);
        checkEq("reset stall", 64'(bus.stall_div), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkEq("idle no start stall", 64'(bus.stall_div), 64'd0);

        runDiv("u100/7", 32'd100, 32'd7, 1'b0, 33, 64'h00000002_0000000E);
        @(negedge clk);
        checkEq("ready one pulse", 64'(bus.ready), 64'd0);
        checkEq("result held", bus.result, 64'h00000002_0000000E);
        @(posedge clk);
        #1;

        runDiv("s-7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, 33, 64'hFFFFFFFF_FFFFFFFD);
        runDiv("s ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 33, 64'h00000000_80000000);
        runDiv("u ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 33, 64'h80000000_00000000);

        // annul in cycle 10 of a 20/3
        bus.a          = 32'd20;
        bus.b          = 32'd3;
        bus.signed_div = 1'b0;
        bus.start      = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        bus.annul = 1'b1;
        @(negedge clk);
        checkEq("annul stall", 64'(bus.stall_div), 64'd0);
        checkEq("annul ready", 64'(bus.ready), 64'd0);
        @(posedge clk);
        #1;
        bus.annul = 1'b0;
        checkEq("annul result kept", bus.result, 64'h80000000_00000000);
        checkEq("annul idle ready", 64'(bus.ready), 64'd0);

        // restart right after annul, then back-to-back 9/4
        runDiv("u20/3", 32'd20, 32'd3, 1'b0, 33, 64'h00000002_00000006);
        runDiv("u9/4", 32'd9, 32'd4, 1'b0, 33, 64'h00000001_00000002);

        runDiv("u5/0", 32'd5, 32'd0, 1'b0, zeroStall, 64'h00000005_FFFFFFFF);
`ifdef DIV_ZERO_FAST_EN
        runDiv("s-5/0", 32'hFFFF_FFFB, 32'd0, 1'b1, 1, 64'hFFFFFFFB_FFFFFFFF);
`else
        runDiv("s-5/0", 32'hFFFF_FFFB, 32'd0, 1'b1, 33, 64'hFFFFFFFB_00000001);
`endif

        // reset in the middle of BUSY
        bus.a          = 32'd1000;
        bus.b          = 32'd9;
        bus.signed_div = 1'b0;
        bus.start      = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        checkEq("busy stall", 64'(bus.stall_div), 64'd1);
        #2;
        rst       = 1'b1;
        bus.start = 1'b0;
        #1;
        checkEq("rst result", bus.result, 64'd0);
        checkEq("rst ready", 64'(bus.ready), 64'd0);
        checkEq("rst stall", 64'(bus.stall_div), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        runDiv("u1000/9", 32'd1000, 32'd9, 1'b0, 33, 64'h00000001_0000006F);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-bit integer divider for the execute stage of the five-stage MIPS pipeline, serving DIV/DIVU. It produces the quotient and remainder for the HI/LO write path. It also drives the divide-stall signal that the hazard unit consumes as `stall_divE`. While a division runs, F/D/E are frozen and M is flushed.

## Interface
Parameters:
- none

Ports:
- `clk` in 1: clock; all state updates on the rising edge
- `rst` in 1: reset, asynchronous, active-high
- `a` in 32: dividend (rs value after E-stage forwarding)
- `b` in 32: divisor (rt value after E-stage forwarding)
- `signed_div` in 1: 1 = DIV, 0 = DIVU
- `start` in 1: a divide instruction occupies E; held high for as long as that instruction stays in E
- `annul` in 1: abort the current operation (exception flush of E)
- `result` out 64: {remainder, quotient}; hi half goes to HI, lo half goes to LO
- `ready` out 1: `result` is valid this cycle
- `stall_div` out 1: to hazard unit `stall_divE`

## Operation
The FSM has three states: IDLE, BUSY, DONE.

IDLE:
- If `start & ~annul`:
  - latch |a| and |b| (or the raw values when unsigned)
  - latch the quotient sign = a[31]^b[31] and the remainder sign = a[31] (only when signed)
  - clear the 6-bit counter
  - go to BUSY

BUSY:
- Perform one restoring step per cycle on a 65-bit partial remainder/quotient register:
  - shift left by 1
  - trial-subtract the divisor from bits [64:32]
  - if the difference is non-negative, keep it and set quotient bit 1
- The counter increments each step.
- After the 32nd step, go to DONE.

DONE:
- `ready` = 1.
- `result` holds the sign-corrected values:
  - quotient negated when the quotient sign is 1
  - remainder negated when the remainder sign is 1
- Return to IDLE unconditionally on the next edge. `start` is ignored while in DONE.

Annul and reset:
- `annul` in any state forces IDLE on the next edge.
- `result` is not updated and `ready` stays 0.

Output rules:
- `stall_div` = `(state==IDLE & start) | state==BUSY`, gated by `~annul`. It is combinational, so the hazard unit sees the stall in the same cycle the divide enters E.
- `result` is registered and holds its value until the next DONE.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0. This needs no special handling; it falls out of the magnitude arithmetic with 32-bit wrap.

## Timing
- Reset values: state IDLE, `result` 0, `ready` 0, counter 0, `stall_div` 0.
- Cycle 0: `start` rises in IDLE, and `stall_div` = 1 the same cycle.
- Cycles 1–32: BUSY, `stall_div` = 1.
- Cycle 33: DONE, `ready` = 1, `stall_div` = 0, `result` valid. The pipeline advances at the end of cycle 33.
- Total: 33 stall cycles.
- Back-to-back divides: a second divide entering E at cycle 34 sees IDLE with `start` = 1 and begins a fresh operation. There is no idle gap.
- `annul` asserted in cycle k: `stall_div` is 0 in cycle k, and the state is IDLE in cycle k+1. A new `start` in cycle k+1 begins a full 33-cycle operation.
- `rst` mid-operation: all registers take their reset values immediately (asynchronous reset).
- `start` low in IDLE: no state change and no register activity.

## Configuration
Macro: `DIV_ZERO_FAST_EN`.

- Defined:
  - `b` == 0 in IDLE with `start` goes straight to DONE.
  - Stall lasts 1 cycle (cycle 0 only).
  - `result` = {a, 32'hFFFFFFFF} regardless of `signed_div`.
- Undefined:
  - A zero divisor runs the full 33-cycle sequence.
  - Restoring yields magnitude quotient 0xFFFFFFFF and remainder |a|, then the sign correction is applied.
  - Example, signed a = -5: quotient 0x00000001, remainder 0xFFFFFFFB.

## Test plan
- Unsigned 100/7:
  - `stall_div` is high for exactly 33 cycles.
  - `ready` pulses for 1 cycle with lo = 14 (0x0E) and hi = 2.
- Signed -7/2 (a = 0xFFFFFFF9, b = 2): lo = 0xFFFFFFFD and hi = 0xFFFFFFFF.
- Signed 0x80000000 / 0xFFFFFFFF: lo = 0x80000000 and hi = 0. Unsigned, same operands: lo = 0 and hi = 0x80000000.
- `annul` in cycle 10 of an operation:
  - `stall_div` = 0 that cycle, no `ready`, and `result` is unchanged.
  - `start` in the next cycle produces a full 33-cycle operation.
- Back-to-back divides: 20/3, then 9/4 starting in cycle 34. Results are lo = 6, hi = 2, then lo = 2, hi = 1. `stall_div` is low only in cycle 33.
- Divide by zero, a = 5, b = 0, run under both configurations:
  - with `DIV_ZERO_FAST_EN`: 1 stall cycle, `result` = {0x5, 0xFFFFFFFF}
  - without it: 33 stall cycles, same unsigned `result`
- `rst` asserted mid-BUSY: `ready`, `result`, and `stall_div` go to 0 asynchronously.
